// File: rtl/hex_scan_driver.sv
// rtl/hex_scan_driver.sv - time-multiplexed seven-segment scanner
// Frame snapshot, dead time, PWM dimming, blank/dp control, leading-zero suppression.
module hex_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_PERIOD = 32768,
  parameter int DEAD_CYCLES  = 256,
  parameter int BRIGHT_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [7:0]              hex_seg,
  output logic [NUM_DIGITS-1:0]   hex_grid,
  output logic                    frame_start
);

  localparam int TICK_BITS = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int TICK_W    = (TICK_BITS > BRIGHT_W) ? TICK_BITS : BRIGHT_W;
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_PERIOD - 1);
  localparam logic [TICK_W-1:0] DEAD_END  = TICK_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [TICK_W-1:0]       tick;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] digits_snap;
  logic [NUM_DIGITS-1:0]   dp_snap;
  logic [NUM_DIGITS-1:0]   blank_snap;
  logic                    lz_snap;
  logic                    snap_edge;
  logic [NUM_DIGITS-1:0]   zero_lead;
  logic                    suffix_zero;
  logic                    dead;
  logic                    lit;
  logic [3:0]              nib;
  logic                    dp_cur;
  logic                    blank_cur;
  logic                    zl_cur;
  logic [7:0]              seg_next;
  logic [NUM_DIGITS-1:0]   grid_next;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  assign snap_edge = (tick == '0) && (idx == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick <= '0;
      idx  <= '0;
    end else if (tick == TICK_LAST) begin
      tick <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  // Inputs are frozen once per frame so a multi-digit value never tears mid-scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits_snap <= '0;
      dp_snap     <= '0;
      blank_snap  <= '0;
      lz_snap     <= 1'b0;
    end else if (snap_edge) begin
      digits_snap <= digits;
      dp_snap     <= dp_en;
      blank_snap  <= blank;
      lz_snap     <= lz_suppress;
    end
  end

  always_comb begin
    zero_lead   = '0;
    suffix_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      suffix_zero  = suffix_zero && (digits_snap[4*i +: 4] == 4'h0);
      zero_lead[i] = lz_snap && (i != 0) && suffix_zero;
    end
  end

  assign dead = (tick < DEAD_END);
  assign lit  = (brightness == '1) || (tick[BRIGHT_W-1:0] < brightness);

  always_comb begin
    nib       = 4'h0;
    dp_cur    = 1'b0;
    blank_cur = 1'b0;
    zl_cur    = 1'b0;
    seg_next  = '1;
    grid_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib       = digits_snap[4*i +: 4];
        dp_cur    = dp_snap[i];
        blank_cur = blank_snap[i];
        zl_cur    = zero_lead[i];
      end
    end
    if (!dead && lit && !blank_cur) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        grid_next[i] = (idx != IDX_W'(i));
      end
      seg_next[6:0] = zl_cur ? 7'h7F : ~glyph(nib);
      seg_next[7]   = ~dp_cur;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_seg     <= '1;
      hex_grid    <= '1;
      frame_start <= 1'b0;
    end else begin
      hex_seg     <= seg_next;
      hex_grid    <= grid_next;
      frame_start <= snap_edge;
    end
  end

endmodule
